fetch_decode: RTL and testbench

- Front end of the multi-cycle core, directly upstream of the ALU stage.
- Pulls instruction bytes from a byte-wide instruction port, assembles a 2–4 byte instruction (opcode, ModRM, optional imm8/disp8 or imm16), and drives the ALU operands ikind, ia, sim8 and im16.
- Generates the 5-bit one-hot phase vector and owns the PC; PC is redirected from the ALU's ct_taken/target.

---
 rtl/fetch_decode_pkg.sv | 42 ++++
 rtl/fetch_decode_if.sv | 43 ++++
 rtl/fetch_decode_length_decode.sv | 26 ++
 rtl/fetch_decode.sv | 155 +++++++++++++++
 tb/tb_fetch_decode.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_decode_pkg.sv
// Shared constants, fetch-state encoding and length/legality helpers for the fetch/decode front end.
// FD_ILLEGAL_TRAP_EN: enables the illegal-opcode trap (fd_opcode_legal is only used then).
package fd_pkg;

    localparam int FD_PH_W = 5;

    localparam logic [FD_PH_W-1:0] PH_FETCH  = 5'b00001;
    localparam logic [FD_PH_W-1:0] PH_DECODE = 5'b00010;
    localparam logic [FD_PH_W-1:0] PH_EXEC   = 5'b00100;
    localparam logic [FD_PH_W-1:0] PH_MEM    = 5'b01000;
    localparam logic [FD_PH_W-1:0] PH_WB     = 5'b10000;

    localparam logic [7:0] OP_LIL = 8'h66;
    localparam logic [7:0] OP_B   = 8'h90;
    localparam logic [7:0] OP_JR  = 8'hFF;

    typedef enum logic [2:0] {
        FS_BYTE0 = 3'd0,
        FS_BYTE1 = 3'd1,
        FS_EXT0  = 3'd2,
        FS_EXT1  = 3'd3,
        FS_DONE  = 3'd4
    } fd_fetch_e;

    // Total instruction length in bytes (2..4) from the opcode and ModRM.mod.
    function automatic logic [2:0] fd_inst_len(input logic [7:0] opcode, input logic [1:0] mod);
        if (opcode == OP_LIL)
            return 3'd4;
        else if (opcode[7:2] == 6'b1000_00 && mod == 2'b11)
            return 3'd3;
        else if (opcode[7:2] == 6'b1000_10 && mod == 2'b01)
            return 3'd3;
        else
            return 3'd2;
    endfunction

    function automatic logic fd_opcode_legal(input logic [7:0] opcode);
        return opcode inside {[8'h00:8'h03], [8'h08:8'h0B], [8'h20:8'h23], [8'h28:8'h2B],
                              OP_LIL, [8'h80:8'h83], [8'h88:8'h8B], OP_B, 8'hF6, 8'hF7, OP_JR};
    endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Byte-fetch, redirect and decoded-operand bundle between fetch_decode (master) and its surroundings (slave).
// FD_ILLEGAL_TRAP_EN adds the illegal flag to the bundle.
interface fetch_decode_if;
    import fd_pkg::*;

    logic [7:0]         ibyte;
    logic               ibyte_valid;
    logic               ibyte_ready;
    logic [31:0]        pc_fetch;
    logic               ct_taken;
    logic [31:0]        br_target;
    logic [FD_PH_W-1:0] phase;
    logic [9:0]         ikind;
    logic [2:0]         ia;
    logic [2:0]         ra_idx;
    logic [2:0]         rb_idx;
    logic [7:0]         sim8;
    logic [15:0]        im16;
    logic [31:0]        pc;

`ifdef FD_ILLEGAL_TRAP_EN
    logic               illegal;

    modport master (
        input  ibyte, ibyte_valid, ct_taken, br_target,
        output ibyte_ready, pc_fetch, phase, ikind, ia, ra_idx, rb_idx, sim8, im16, pc, illegal
    );
    modport slave (
        output ibyte, ibyte_valid, ct_taken, br_target,
        input  ibyte_ready, pc_fetch, phase, ikind, ia, ra_idx, rb_idx, sim8, im16, pc, illegal
    );
`else
    modport master (
        input  ibyte, ibyte_valid, ct_taken, br_target,
        output ibyte_ready, pc_fetch, phase, ikind, ia, ra_idx, rb_idx, sim8, im16, pc
    );
    modport slave (
        output ibyte, ibyte_valid, ct_taken, br_target,
        input  ibyte_ready, pc_fetch, phase, ikind, ia, ra_idx, rb_idx, sim8, im16, pc
    );
`endif

endinterface

// File: rtl/fetch_decode_length_decode.sv
// Combinational classifier: instruction length and ALU operand fields from opcode + ModRM.
// FD_ILLEGAL_TRAP_EN: o_illegal flags opcodes outside the supported set; otherwise it is tied low.
module fd_length_decode
    import fd_pkg::*;
(
    input  logic [7:0] i_opcode,
    input  logic [7:0] i_modrm,
    output logic [2:0] o_len,
    output logic [9:0] o_ikind,
    output logic [2:0] o_reg,
    output logic [2:0] o_rm,
    output logic       o_illegal
);

    assign o_len   = fd_inst_len(i_opcode, i_modrm[7:6]);
    assign o_ikind = {i_opcode, i_modrm[7:6]};
    assign o_reg   = i_modrm[5:3];
    assign o_rm    = i_modrm[2:0];

`ifdef FD_ILLEGAL_TRAP_EN
    assign o_illegal = !fd_opcode_legal(i_opcode);
`else
    assign o_illegal = 1'b0;
`endif

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode front end: assembles 2-4 byte instructions, owns the PC and the one-hot phase ring.
// FD_ILLEGAL_TRAP_EN: traps unsupported opcodes at DONE and freezes until reset.
module fetch_decode
    import fd_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PHASES   = 5
) (
    input  logic           CLK,
    input  logic           RST,
    fetch_decode_if.master fd
);

    localparam logic [2:0] ST_BYTE0 = 3'(FS_BYTE0);
    localparam logic [2:0] ST_BYTE1 = 3'(FS_BYTE1);
    localparam logic [2:0] ST_EXT0  = 3'(FS_EXT0);
    localparam logic [2:0] ST_EXT1  = 3'(FS_EXT1);
    localparam logic [2:0] ST_DONE  = 3'(FS_DONE);

    logic [2:0]        r_state;
    logic [PHASES-1:0] r_phase;
    logic [31:0]       r_pc;
    logic [31:0]       r_pc_fetch;
    logic [7:0]        r_op;
    logic [7:0]        r_modrm;
    logic [7:0]        r_ext0;
    logic [7:0]        r_ext1;
    logic [2:0]        r_len;
    logic              r_taken;
    logic [31:0]       r_target;
    logic [9:0]        r_ikind;
    logic [2:0]        r_ia;
    logic [2:0]        r_rb;
    logic [7:0]        r_sim8;
    logic [15:0]       r_im16;
    logic              r_illegal;

    logic              w_fetching;
    logic              w_ready;
    logic              w_take;
    logic              w_done;
    logic [7:0]        w_modrm;
    logic [2:0]        w_len;
    logic [9:0]        w_ikind;
    logic [2:0]        w_reg;
    logic [2:0]        w_rm;
    logic              w_illegal;
    logic [PHASES-1:0] w_phase_rot;

    assign w_fetching  = r_phase[0] && !r_illegal && (r_state != ST_DONE);
    assign w_ready     = w_fetching && !RST;
    assign w_take      = w_ready && fd.ibyte_valid;
    assign w_done      = r_phase[0] && !r_illegal && (r_state == ST_DONE);
    assign w_phase_rot = {r_phase[PHASES-2:0], r_phase[PHASES-1]};

    // The length decision is made while ModRM is on the bus, so classify the live byte in BYTE1.
    assign w_modrm = (r_state == ST_BYTE1) ? fd.ibyte : r_modrm;

    fd_length_decode u_len (
        .i_opcode  (r_op),
        .i_modrm   (w_modrm),
        .o_len     (w_len),
        .o_ikind   (w_ikind),
        .o_reg     (w_reg),
        .o_rm      (w_rm),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_BYTE0;
            r_phase    <= {{(PHASES-1){1'b0}}, 1'b1};
            r_pc       <= RESET_PC;
            r_pc_fetch <= RESET_PC;
            r_op       <= 8'h00;
            r_modrm    <= 8'h00;
            r_ext0     <= 8'h00;
            r_ext1     <= 8'h00;
            r_len      <= 3'd2;
            r_taken    <= 1'b0;
            r_target   <= 32'h0000_0000;
            r_ikind    <= 10'h000;
            r_ia       <= 3'd0;
            r_rb       <= 3'd0;
            r_sim8     <= 8'h00;
            r_im16     <= 16'h0000;
            r_illegal  <= 1'b0;
        end else begin
            if (w_take) begin
                r_pc_fetch <= r_pc_fetch + 32'd1;
                case (r_state)
                    ST_BYTE0: begin
                        r_op    <= fd.ibyte;
                        r_state <= ST_BYTE1;
                    end
                    ST_BYTE1: begin
                        r_modrm <= fd.ibyte;
                        r_len   <= w_len;
                        r_state <= (w_len == 3'd2) ? ST_DONE : ST_EXT0;
                    end
                    ST_EXT0: begin
                        r_ext0  <= fd.ibyte;
                        r_state <= (r_len == 3'd4) ? ST_EXT1 : ST_DONE;
                    end
                    ST_EXT1: begin
                        r_ext1  <= fd.ibyte;
                        r_state <= ST_DONE;
                    end
                    default: r_state <= ST_BYTE0;
                endcase
            end else if (r_phase[PHASES-1]) begin
                r_pc_fetch <= r_taken ? r_target : r_pc_fetch;
            end

            if (w_done) begin
                r_ikind <= w_ikind;
                r_ia    <= w_reg;
                r_rb    <= w_rm;
                r_sim8  <= (r_len == 3'd3) ? r_ext0 : 8'h00;
                r_im16  <= (r_len == 3'd4) ? {r_ext1, r_ext0} : 16'h0000;
                r_state <= ST_BYTE0;
                if (w_illegal)
                    r_illegal <= 1'b1;
                else
                    r_phase <= w_phase_rot;
            end else if (!r_phase[0]) begin
                r_phase <= w_phase_rot;
            end

            // The ALU's branch decision is only valid during the memory phase.
            if (r_phase[3]) begin
                r_taken  <= fd.ct_taken;
                r_target <= fd.br_target;
            end

            if (r_phase[PHASES-1])
                r_pc <= r_taken ? r_target : r_pc + {29'd0, r_len};
        end
    end

    assign fd.ibyte_ready = w_ready;
    assign fd.pc_fetch    = r_pc_fetch;
    assign fd.phase       = r_phase;
    assign fd.ikind       = r_ikind;
    assign fd.ia          = r_ia;
    assign fd.ra_idx      = r_ia;
    assign fd.rb_idx      = r_rb;
    assign fd.sim8        = r_sim8;
    assign fd.im16        = r_im16;
    assign fd.pc          = r_pc;
`ifdef FD_ILLEGAL_TRAP_EN
    assign fd.illegal     = r_illegal;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: directed vector table, hand-written reset/trap sequences, random stream.
// FD_ILLEGAL_TRAP_EN selects the trap sequence instead of the unknown-opcode pass-through case.
module tb_fetch_decode;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_decode_if bus();

    fetch_decode #(.RESET_PC(32'h0000_0000), .PHASES(5)) dut (
        .CLK (clk),
        .RST (rst),
        .fd  (bus)
    );

    typedef struct {
        logic [31:0] bytes;
        int          n;
        int          gap;
        logic        taken;
        logic [31:0] tgt;
        logic [9:0]  ikind;
        logic [7:0]  sim8;
        logic [15:0] im16;
    } vec_t;

    vec_t        tbl [8];
    logic [7:0]  ops [0:13];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] m_pc;
    logic [31:0] m_fetch;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req)
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
        else
            n_pass++;
    endtask

    // Reference length rule, written directly from the opcode/mod table.
    function automatic int ref_len(input logic [7:0] op, input logic [7:0] modrm);
        if (op == 8'h66) return 4;
        if (op inside {[8'h80:8'h83]} && modrm[7:6] == 2'b11) return 3;
        if (op inside {[8'h88:8'h8B]} && modrm[7:6] == 2'b01) return 3;
        return 2;
    endfunction

    task automatic feed_byte(input logic [7:0] b, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.ibyte_valid = 1'b0;
            bus.ibyte       = 8'($urandom);
            check("stall_phase", 32'(bus.phase), 32'h1);
        end
        @(negedge clk);
        bus.ibyte       = b;
        bus.ibyte_valid = 1'b1;
        waited = 0;
        while (bus.ibyte_ready !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("byte_ready", 32'(bus.ibyte_ready), 32'h1);
        check("pc_fetch", bus.pc_fetch, m_fetch);
        m_fetch = m_fetch + 32'd1;
    endtask

    task automatic run_instr(input logic [31:0] bytes, input int n, input int gap, input logic taken,
                             input logic [31:0] tgt, input logic [9:0] e_ikind, input logic [7:0] e_sim8,
                             input logic [15:0] e_im16);
        logic [7:0] modrm;
        modrm = bytes[15:8];
        for (int i = 0; i < n; i++) feed_byte(bytes[8*i +: 8], gap);
        @(negedge clk);
        bus.ibyte       = 8'($urandom);
        bus.ibyte_valid = 1'b1;
        check("done_phase", 32'(bus.phase), 32'h1);
        check("done_ready", 32'(bus.ibyte_ready), 32'h0);
        for (int p = 1; p <= 4; p++) begin
            @(negedge clk);
            check("phase_seq", 32'(bus.phase), 32'h1 << p);
            check("busy_ready", 32'(bus.ibyte_ready), 32'h0);
            if (p == 1 || p == 4) begin
                check("ikind", 32'(bus.ikind), 32'(e_ikind));
                check("ia", 32'(bus.ia), 32'(modrm[5:3]));
                check("ra_idx", 32'(bus.ra_idx), 32'(modrm[5:3]));
                check("rb_idx", 32'(bus.rb_idx), 32'(modrm[2:0]));
                check("sim8", 32'(bus.sim8), 32'(e_sim8));
                check("im16", 32'(bus.im16), 32'(e_im16));
                check("pc_hold", bus.pc, m_pc);
                check("pc_fetch_hold", bus.pc_fetch, m_fetch);
            end
            if (p == 3) begin
                bus.ct_taken  = taken;
                bus.br_target = tgt;
            end else begin
                bus.ct_taken  = ~taken;
                bus.br_target = $urandom;
            end
        end
        @(negedge clk);
        bus.ibyte_valid = 1'b0;
        bus.ct_taken    = 1'b0;
        m_pc    = taken ? tgt : m_pc + 32'(n);
        m_fetch = m_pc;
        check("next_phase", 32'(bus.phase), 32'h1);
        check("next_pc", bus.pc, m_pc);
        check("next_pc_fetch", bus.pc_fetch, m_fetch);
        $display("instr bytes=%h len=%0d taken=%0b -> pc=%h", bytes, n, taken, m_pc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h0000_C101, 2, 0, 1'b0, 32'h0000_0000,  10'h007, 8'h00, 16'h0000};
        tbl[1] = '{32'h1234_8066, 4, 0, 1'b0, 32'h0000_0000,  10'h19A, 8'h00, 16'h1234};
        tbl[2] = '{32'h0005_C083, 3, 3, 1'b0, 32'h0000_0000,  10'h20F, 8'h05, 16'h0000};
        tbl[3] = '{32'h0000_E3FF, 2, 0, 1'b1, 32'h0000_0100,  10'h3FF, 8'h00, 16'h0000};
        tbl[4] = '{32'h007F_4588, 3, 1, 1'b1, 32'hFFFF_FFFE,  10'h221, 8'h7F, 16'h0000};
        tbl[5] = '{32'hABCD_C066, 4, 0, 1'b0, 32'h0000_0000,  10'h19B, 8'h00, 16'hABCD};
        tbl[6] = '{32'h0000_4080, 2, 0, 1'b0, 32'h0000_0000,  10'h201, 8'h00, 16'h0000};
        tbl[7] = '{32'h0000_C088, 2, 2, 1'b0, 32'h0000_0000,  10'h223, 8'h00, 16'h0000};
        ops = '{8'h00, 8'h03, 8'h09, 8'h22, 8'h2B, 8'h66, 8'h80, 8'h81,
                8'h83, 8'h88, 8'h8B, 8'h90, 8'hF6, 8'hFF};

        rst             = 1'b1;
        bus.ibyte       = 8'h00;
        bus.ibyte_valid = 1'b0;
        bus.ct_taken    = 1'b0;
        bus.br_target   = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_phase", 32'(bus.phase), 32'h1);
        check("rst_pc", bus.pc, 32'h0);
        check("rst_pc_fetch", bus.pc_fetch, 32'h0);
        check("rst_ready", 32'(bus.ibyte_ready), 32'h0);
        check("rst_ikind", 32'(bus.ikind), 32'h0);
        check("rst_sim8", 32'(bus.sim8), 32'h0);
        check("rst_im16", 32'(bus.im16), 32'h0);
`ifdef FD_ILLEGAL_TRAP_EN
        check("rst_illegal", 32'(bus.illegal), 32'h0);
`endif
        rst     = 1'b0;
        m_pc    = 32'h0;
        m_fetch = 32'h0;

        for (int i = 0; i < 8; i++)
            run_instr(tbl[i].bytes, tbl[i].n, tbl[i].gap, tbl[i].taken, tbl[i].tgt,
                      tbl[i].ikind, tbl[i].sim8, tbl[i].im16);

        // Reset in the middle of a 4-byte instruction, then a fresh 2-byte add.
        feed_byte(8'h66, 0);
        feed_byte(8'h80, 0);
        @(negedge clk);
        bus.ibyte_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_pc", bus.pc, 32'h0);
        check("mid_rst_pc_fetch", bus.pc_fetch, 32'h0);
        check("mid_rst_phase", 32'(bus.phase), 32'h1);
        check("mid_rst_ready", 32'(bus.ibyte_ready), 32'h0);
        check("mid_rst_ikind", 32'(bus.ikind), 32'h0);
        @(negedge clk);
        rst     = 1'b0;
        m_pc    = 32'h0;
        m_fetch = 32'h0;
        run_instr(32'h0000_C101, 2, 0, 1'b0, 32'h0, 10'h007, 8'h00, 16'h0000);

        for (int k = 0; k < 25; k++) begin
            logic [7:0]  op, modrm, e0, e1;
            logic        tk;
            logic [31:0] tgt;
            int          len;
            op    = ops[$urandom_range(0, 13)];
            modrm = 8'($urandom);
            e0    = 8'($urandom);
            e1    = 8'($urandom);
            tk    = ($urandom_range(0, 3) == 0);
            tgt   = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFD : $urandom;
            len   = ref_len(op, modrm);
            run_instr({e1, e0, modrm, op}, len, $urandom_range(0, 2), tk, tgt, {op, modrm[7:6]},
                      (len == 3) ? e0 : 8'h00, (len == 4) ? {e1, e0} : 16'h0000);
        end

`ifdef FD_ILLEGAL_TRAP_EN
        feed_byte(8'h0F, 0);
        feed_byte(8'hC0, 0);
        @(negedge clk);
        bus.ibyte       = 8'h01;
        bus.ibyte_valid = 1'b1;
        @(negedge clk);
        check("trap_illegal", 32'(bus.illegal), 32'h1);
        check("trap_phase", 32'(bus.phase), 32'h1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("trap_ready", 32'(bus.ibyte_ready), 32'h0);
        end
        check("trap_pc_fetch", bus.pc_fetch, m_fetch);
        #2 rst = 1'b1;
        #1;
        check("trap_rst_illegal", 32'(bus.illegal), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.ibyte_valid = 1'b0;
        $display("illegal trap sequence done");
`else
        run_instr(32'h0000_C00F, 2, 1, 1'b0, 32'h0, 10'h03F, 8'h00, 16'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
